pipelined_multiplier: RTL and testbench

PIPELINED_MULTIPLIER -- requirements
Module: pipelined_multiplier

---
 rtl/pipelined_multiplier.sv | 144 ++++++++++++++
 tb/tb_pipelined_multiplier.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_multiplier.sv
// Three-stage pipelined WIDTH x WIDTH multiplier with valid/ready handshake.
//   S0 captures the operands, S1 forms two half-row partial sums, S2 adds them into P.
// A global enable freezes every stage. Optional signed support is compiled in
// when PIPELINED_MULTIPLIER_SIGNED_EN is defined. Otherwise the Signed port is kept
// but ignored, and no sign-extension logic is built.
module pipelined_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               En,
  input  logic               In_valid,
  output logic               In_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               Signed,
  output logic               Out_valid,
  input  logic               Out_ready,
  output logic [2*WIDTH-1:0] P
);

  localparam int PW   = 2 * WIDTH;
  localparam int HALF = WIDTH / 2;

  // Stage valid bits
  logic v0, v1, v2;

  // S0 operand registers
  logic [WIDTH-1:0] a0, b0;
`ifdef PIPELINED_MULTIPLIER_SIGNED_EN
  logic             sgn0;
`else
  logic             unused_signed;
  assign unused_signed = Signed;
`endif

  // S1 partial-sum registers
  logic [PW-1:0] sum_lo1, sum_hi1;

  // Combinational partial sums computed from S0
  logic [PW-1:0] ext_a;
  logic [PW-1:0] lo_sum, hi_sum;

  // Handshake terms
  logic pop;
  logic adv0, adv1;
  logic run;

  // A stage may move forward only if the pipeline is running and the stage after it
  // has room. Room means that stage is empty, or it moves forward in this same cycle.
  // This chain is combinational from Out_ready back to In_ready.
  assign run       = En & Reset_n;
  assign Out_valid = v2 & run;
  assign pop       = Out_valid & Out_ready;
  assign adv1      = run & (~v2 | pop);
  assign adv0      = run & (~v1 | adv1);
  assign In_ready  = run & (~v0 | adv0);

  // Build the two half partial sums. The multiplicand is extended to the full product
  // width. In signed mode, the top multiplier bit has negative weight, so its row is
  // subtracted instead of added. All arithmetic wraps modulo 2^PW, which gives the
  // exact two's-complement product.
  always_comb begin
    ext_a  = {{WIDTH{1'b0}}, a0};
`ifdef PIPELINED_MULTIPLIER_SIGNED_EN
    if (sgn0) begin
      ext_a = {{WIDTH{a0[WIDTH-1]}}, a0};
    end
`endif
    lo_sum = '0;
    hi_sum = '0;
    for (int i = 0; i < HALF; i++) begin
      if (b0[i]) begin
        lo_sum = lo_sum + (ext_a << i);
      end
    end
    for (int i = HALF; i < WIDTH; i++) begin
      if (b0[i]) begin
`ifdef PIPELINED_MULTIPLIER_SIGNED_EN
        if (sgn0 && (i == WIDTH - 1)) begin
          hi_sum = hi_sum - (ext_a << i);
        end else begin
          hi_sum = hi_sum + (ext_a << i);
        end
`else
        hi_sum = hi_sum + (ext_a << i);
`endif
      end
    end
  end

  // S0: capture the operands whenever the input side is ready.
  // If no operands are offered, a bubble is captured instead.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      v0   <= 1'b0;
      a0   <= '0;
      b0   <= '0;
`ifdef PIPELINED_MULTIPLIER_SIGNED_EN
      sgn0 <= 1'b0;
`endif
    end else if (In_ready) begin
      v0 <= In_valid;
      if (In_valid) begin
        a0   <= A;
        b0   <= B;
`ifdef PIPELINED_MULTIPLIER_SIGNED_EN
        sgn0 <= Signed;
`endif
      end
    end
  end

  // S1: register the two partial sums when S0 moves forward.
  // The data is left untouched when S0 carries a bubble.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      v1      <= 1'b0;
      sum_lo1 <= '0;
      sum_hi1 <= '0;
    end else if (adv0) begin
      v1 <= v0;
      if (v0) begin
        sum_lo1 <= lo_sum;
        sum_hi1 <= hi_sum;
      end
    end
  end

  // S2: add the partial sums into P. P keeps its last value after a pop until a
  // real product replaces it.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      v2 <= 1'b0;
      P  <= '0;
    end else if (adv1) begin
      v2 <= v1;
      if (v1) begin
        P <= sum_lo1 + sum_hi1;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Self-checking bench for pipelined_multiplier (WIDTH=8 main instance plus a WIDTH=16 instance).
// Table-driven directed vectors, hand-written stall/reset/enable sequences, and a randomized
// scoreboard run against an arithmetic reference model.
module tb_pipelined_multiplier;

`ifdef PIPELINED_MULTIPLIER_SIGNED_EN
  localparam bit SIGNED_MODE = 1'b1;
`else
  localparam bit SIGNED_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en, in_valid, in_ready, sgn, out_valid, out_ready;
  logic [7:0]  a, b;
  logic [15:0] p;

  logic        en16, in_valid16, in_ready16, sgn16, out_valid16, out_ready16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] expected;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [31:0] got16_q[$];

  always #5 clk = ~clk;

  pipelined_multiplier #(.WIDTH(8)) dut (
    .Clk(clk), .Reset_n(reset_n), .En(en), .In_valid(in_valid), .In_ready(in_ready),
    .A(a), .B(b), .Signed(sgn), .Out_valid(out_valid), .Out_ready(out_ready), .P(p)
  );

  pipelined_multiplier #(.WIDTH(16)) dut16 (
    .Clk(clk), .Reset_n(reset_n), .En(en16), .In_valid(in_valid16), .In_ready(in_ready16),
    .A(a16), .B(b16), .Signed(sgn16), .Out_valid(out_valid16), .Out_ready(out_ready16), .P(p16)
  );

  // Exact product from plain integer arithmetic
  function automatic logic [15:0] ref8(logic [7:0] x, logic [7:0] y, logic s);
    int xs, ys;
    xs = int'(x);
    ys = int'(y);
    if (s && SIGNED_MODE) begin
      xs = int'($signed(x));
      ys = int'($signed(y));
    end
    return 16'(xs * ys);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] x, input logic [7:0] y, input logic s);
    in_valid = v;
    a        = x;
    b        = y;
    sgn      = s;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  initial begin
    int          accepted;
    logic        held;
    logic [15:0] held_p;

    vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[1] = '{8'h00, 8'h00, 1'b0, 16'h0000};
    vecs[2] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[3] = '{8'hFF, 8'h01, 1'b1, SIGNED_MODE ? 16'hFFFF : 16'h00FF};
    vecs[4] = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, SIGNED_MODE ? 16'h0001 : 16'hFE01};
    vecs[6] = '{8'h7F, 8'h80, 1'b1, SIGNED_MODE ? 16'hC080 : 16'h3F80};
    vecs[7] = '{8'hAA, 8'h55, 1'b0, 16'h3872};

    reset_n    = 1'b0;
    en         = 1'b1;
    out_ready  = 1'b1;
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0);
    en16       = 1'b1;
    in_valid16 = 1'b0;
    a16        = '0;
    b16        = '0;
    sgn16      = 1'b0;
    out_ready16 = 1'b1;

    // Reset behaviour
    tick();
    tick();
    settle();
    checkOutput("rst_in_ready", 32'(in_ready), 32'h0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    reset_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    settle();
    checkOutput("post_rst_p", 32'(p), 32'h0);
    checkOutput("post_rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'h1);
    tick();

    // Table-driven directed vectors: latency and P hold after the pop
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].s);
      out_ready = 1'b1;
      settle();
      checkOutput($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'h1);
      tick();
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
      settle();
      checkOutput($sformatf("tbl%0d_lat_s0", i), 32'(out_valid), 32'h0);
      tick();
      settle();
      checkOutput($sformatf("tbl%0d_lat_s1", i), 32'(out_valid), 32'h0);
      tick();
      settle();
      checkOutput($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'h1);
      checkOutput($sformatf("tbl%0d_p", i), 32'(p), 32'(vecs[i].expected));
      tick();
      settle();
      checkOutput($sformatf("tbl%0d_popped", i), 32'(out_valid), 32'h0);
      checkOutput($sformatf("tbl%0d_p_hold", i), 32'(p), 32'(vecs[i].expected));
    end

    // Back-to-back inputs into a blocked output: only three fit
    out_ready = 1'b0;
    accepted  = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, 8'(accepted + 1), 8'(accepted + 1), 1'b0);
      settle();
      if (in_ready) accepted++;
      tick();
    end
    settle();
    checkOutput("full_accepted", 32'(accepted), 32'd3);
    checkOutput("full_in_ready", 32'(in_ready), 32'h0);
    checkOutput("full_head_valid", 32'(out_valid), 32'h1);
    checkOutput("full_head_p", 32'(p), 32'd1);
    out_ready = 1'b1;
    got_q.delete();
    settle();
    checkOutput("full_pop_accept", 32'(in_ready), 32'h1);
    for (int c = 0; c < 40 && got_q.size() < 6; c++) begin
      applyStimulus(accepted < 6, 8'(accepted + 1), 8'(accepted + 1), 1'b0);
      settle();
      if (out_valid) got_q.push_back(p);
      if (in_valid && in_ready) accepted++;
      tick();
    end
    checkOutput("drain_count", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      checkOutput($sformatf("drain_%0d", i), 32'(got_q[i]), 32'((i + 1) * (i + 1)));
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    tick();

    // Reset with two operations in flight
    applyStimulus(1'b1, 8'd7, 8'd9, 1'b0);
    tick();
    applyStimulus(1'b1, 8'd8, 8'd8, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    reset_n = 1'b0;
    settle();
    checkOutput("midrst_in_ready", 32'(in_ready), 32'h0);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'h0);
    tick();
    reset_n = 1'b1;
    settle();
    checkOutput("midrst_after_valid", 32'(out_valid), 32'h0);
    checkOutput("midrst_after_p", 32'(p), 32'h0);
    accepted = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      settle();
      if (out_valid) accepted++;
    end
    checkOutput("midrst_no_ghost", 32'(accepted), 32'd0);
    applyStimulus(1'b1, 8'd3, 8'd5, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    settle();
    checkOutput("midrst_new_valid", 32'(out_valid), 32'h1);
    checkOutput("midrst_new_p", 32'(p), 32'h000F);
    tick();

    // Enable low freezes a partially filled pipeline
    out_ready = 1'b0;
    applyStimulus(1'b1, 8'd10, 8'd10, 1'b0);
    tick();
    applyStimulus(1'b1, 8'd11, 8'd11, 1'b0);
    tick();
    en = 1'b0;
    applyStimulus(1'b1, 8'd2, 8'd2, 1'b0);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      checkOutput($sformatf("en0_in_ready_%0d", c), 32'(in_ready), 32'h0);
      checkOutput($sformatf("en0_out_valid_%0d", c), 32'(out_valid), 32'h0);
      tick();
    end
    en = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    got_q.delete();
    for (int c = 0; c < 10; c++) begin
      settle();
      if (out_valid) got_q.push_back(p);
      tick();
    end
    checkOutput("en_resume_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() >= 2) begin
      checkOutput("en_resume_0", 32'(got_q[0]), 32'd100);
      checkOutput("en_resume_1", 32'(got_q[1]), 32'd121);
    end

    // Randomized traffic against the reference model
    exp_q.delete();
    held   = 1'b0;
    held_p = '0;
    for (int c = 0; c < 400; c++) begin
      en        = ($urandom_range(0, 7) != 0);
      out_ready = $urandom_range(0, 2) != 0;
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      settle();
      if (!en) begin
        checkOutput("rnd_en0_in_ready", 32'(in_ready), 32'h0);
        checkOutput("rnd_en0_out_valid", 32'(out_valid), 32'h0);
      end else if (held) begin
        checkOutput("rnd_hold_valid", 32'(out_valid), 32'h1);
        checkOutput("rnd_hold_p", 32'(p), 32'(held_p));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("rnd_unexpected_out", 32'h1, 32'h0);
        end else begin
          checkOutput("rnd_product", 32'(p), 32'(exp_q.pop_front()));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref8(a, b, sgn));
      if (en) begin
        held   = out_valid && !out_ready;
        held_p = p;
      end
      tick();
    end
    en        = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    for (int c = 0; c < 20; c++) begin
      settle();
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("rnd_drain_extra", 32'h1, 32'h0);
        end else begin
          checkOutput("rnd_drain_product", 32'(p), 32'(exp_q.pop_front()));
        end
      end
      tick();
    end
    checkOutput("rnd_leftover", 32'(exp_q.size()), 32'd0);

    // WIDTH=16 instance
    settle();
    checkOutput("w16_in_ready", 32'(in_ready16), 32'h1);
    in_valid16 = 1'b1;
    a16 = 16'hFFFF;
    b16 = 16'hFFFF;
    sgn16 = 1'b0;
    tick();
    a16 = 16'hFFFF;
    b16 = 16'h0001;
    sgn16 = 1'b1;
    tick();
    in_valid16 = 1'b0;
    got16_q.delete();
    for (int c = 0; c < 10; c++) begin
      settle();
      if (out_valid16) got16_q.push_back(p16);
      tick();
    end
    checkOutput("w16_count", 32'(got16_q.size()), 32'd2);
    if (got16_q.size() >= 2) begin
      checkOutput("w16_unsigned", got16_q[0], 32'hFFFE0001);
      checkOutput("w16_signed_flag", got16_q[1], SIGNED_MODE ? 32'hFFFFFFFF : 32'h0000FFFF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
